// File: rtl/indegree_tracker.sv
`default_nettype none
// ============================================================================
// Module  : indegree_tracker
// Brief   : Per-node in-degree table with zero-degree FWFT output queue.
//           Optional INDEGREE_UNDERFLOW_CHECK_EN adds a sticky underflow port.
// Revision: 1.0
// ============================================================================
module indegree_tracker #(
    parameter int MAX_NODES    = 1024,
    parameter int NODE_WIDTH   = $clog2(MAX_NODES),
    parameter int DEGREE_WIDTH = 8,
    parameter int ZQ_DEPTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    output logic                    busy,
    input  logic                    inc_valid,
    output logic                    inc_ready,
    input  logic [NODE_WIDTH-1:0]   inc_node,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [NODE_WIDTH-1:0]   dec_node,
    output logic                    deg_valid,
    output logic [DEGREE_WIDTH-1:0] deg_value,
    output logic                    zq_valid,
    input  logic                    zq_ready,
    output logic [NODE_WIDTH-1:0]   zq_node,
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
    output logic                    underflow,
`endif
    output logic                    overflow
);

    localparam int                      QA        = $clog2(ZQ_DEPTH);
    localparam logic [DEGREE_WIDTH-1:0] C_DEG_MAX = '1;
    localparam logic [NODE_WIDTH-1:0]   C_LAST    = NODE_WIDTH'(MAX_NODES - 1);
    localparam logic [QA:0]             C_ROOM    = (QA+1)'(ZQ_DEPTH - 2);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                   r_state;
    logic [NODE_WIDTH-1:0]    r_sweep_idx;
    logic [DEGREE_WIDTH-1:0]  r_table [MAX_NODES];

    logic                     r_wr_valid;
    logic [NODE_WIDTH-1:0]    r_wr_node;
    logic [DEGREE_WIDTH-1:0]  r_wr_data;

    logic [NODE_WIDTH-1:0]    r_zq_mem [ZQ_DEPTH];
    logic [QA-1:0]            r_zq_wptr;
    logic [QA-1:0]            r_zq_rptr;
    logic [QA:0]              r_zq_count;

    logic                     w_run;
    logic                     w_inc_acc;
    logic                     w_dec_acc;
    logic                     w_dec_ok;
    logic                     w_dec_under;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_sat;
    logic [NODE_WIDTH-1:0]    w_rd_node;
    logic [DEGREE_WIDTH-1:0]  w_old;
    logic [DEGREE_WIDTH-1:0]  w_new;

    assign busy      = (r_state == ST_CLEAR);
    assign w_run     = (r_state == ST_RUN) && !clear;
    assign inc_ready = w_run;
    // Two free slots keeps a push legal even when a pop is not happening.
    assign dec_ready = w_run && !inc_valid && (r_zq_count <= C_ROOM);

    assign w_inc_acc = inc_valid && inc_ready;
    assign w_dec_acc = dec_valid && dec_ready;
    assign w_rd_node = w_inc_acc ? inc_node : dec_node;

    // The pending write from the previous acceptance is newer than the RAM.
    assign w_old = (r_wr_valid && (r_wr_node == w_rd_node)) ? r_wr_data
                                                            : r_table[w_rd_node];
    assign w_sat = (w_old == C_DEG_MAX);
    assign w_new = w_inc_acc ? (w_sat ? w_old : w_old + 1'b1) : w_old - 1'b1;

`ifdef INDEGREE_UNDERFLOW_CHECK_EN
    assign w_dec_under = w_dec_acc && (w_old == '0);
`else
    assign w_dec_under = 1'b0;
`endif
    assign w_dec_ok = w_dec_acc && !w_dec_under;
    assign w_push   = w_dec_ok && (w_new == '0);
    assign w_pop    = zq_valid && zq_ready;

    assign zq_valid = (r_zq_count != '0);
    assign zq_node  = zq_valid ? r_zq_mem[r_zq_rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_sweep_idx <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_node   <= '0;
            r_wr_data   <= '0;
            deg_valid   <= 1'b0;
            deg_value   <= '0;
            overflow    <= 1'b0;
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
            underflow   <= 1'b0;
`endif
            r_zq_wptr   <= '0;
            r_zq_rptr   <= '0;
            r_zq_count  <= '0;
        end else if (clear) begin
            r_state     <= ST_CLEAR;
            r_sweep_idx <= '0;
            r_wr_valid  <= 1'b0;
            deg_valid   <= 1'b0;
            overflow    <= 1'b0;
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
            underflow   <= 1'b0;
`endif
            r_zq_wptr   <= '0;
            r_zq_rptr   <= '0;
            r_zq_count  <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_sweep_idx == C_LAST) r_state <= ST_RUN;
                    else                       r_sweep_idx <= r_sweep_idx + 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase

            r_wr_valid <= w_inc_acc || w_dec_ok;
            r_wr_node  <= w_rd_node;
            r_wr_data  <= w_new;
            deg_valid  <= w_dec_ok;
            if (w_dec_ok)           deg_value <= w_new;
            if (w_inc_acc && w_sat) overflow  <= 1'b1;
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
            if (w_dec_under)        underflow <= 1'b1;
`endif

            if (w_push) r_zq_wptr <= r_zq_wptr + 1'b1;
            if (w_pop)  r_zq_rptr <= r_zq_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_zq_count <= r_zq_count + 1'b1;
                2'b01:   r_zq_count <= r_zq_count - 1'b1;
                default: r_zq_count <= r_zq_count;
            endcase
        end
    end

    // Table contents are initialised only by the sweep.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR)
            r_table[r_sweep_idx] <= '0;
        else if (r_wr_valid)
            r_table[r_wr_node] <= r_wr_data;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_zq_mem[r_zq_wptr] <= w_rd_node;
    end

endmodule
`default_nettype wire

// File: tb/tb_indegree_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_indegree_tracker
// Brief   : Scoreboard bench for indegree_tracker against an array model.
// Revision: 1.0
// ============================================================================
module tb_indegree_tracker;

    localparam int N  = 16;
    localparam int NW = 4;
    localparam int DW = 2;
    localparam int ZD = 4;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          busy;
    logic          inc_valid = 1'b0;
    logic          inc_ready;
    logic [NW-1:0] inc_node = '0;
    logic          dec_valid = 1'b0;
    logic          dec_ready;
    logic [NW-1:0] dec_node = '0;
    logic          deg_valid;
    logic [DW-1:0] deg_value;
    logic          zq_valid;
    logic          zq_ready = 1'b0;
    logic [NW-1:0] zq_node;
    logic          overflow;
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
    logic          underflow;
`endif

    indegree_tracker #(
        .MAX_NODES   (N),
        .NODE_WIDTH  (NW),
        .DEGREE_WIDTH(DW),
        .ZQ_DEPTH    (ZD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (busy),
        .inc_valid(inc_valid),
        .inc_ready(inc_ready),
        .inc_node (inc_node),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_node (dec_node),
        .deg_valid(deg_valid),
        .deg_value(deg_value),
        .zq_valid (zq_valid),
        .zq_ready (zq_ready),
        .zq_node  (zq_node),
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
        .underflow(underflow),
`endif
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int model [N];
    bit m_ovf = 1'b0;
    bit m_ufl = 1'b0;
    int exp_deg [$];
    int exp_zq  [$];
    bit rand_zq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && deg_valid) begin
            if (exp_deg.size() == 0) chk("deg_unexpected", {31'd0, deg_valid}, 0);
            else                     chk("deg_value", {30'd0, deg_value}, exp_deg.pop_front());
        end
        if (rst_n && zq_valid && zq_ready) begin
            if (exp_zq.size() == 0) chk("zq_unexpected", {31'd0, zq_valid}, 0);
            else                    chk("zq_node", {28'd0, zq_node}, exp_zq.pop_front());
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = 0;
        m_ovf = 1'b0;
        m_ufl = 1'b0;
        exp_zq.delete();
        exp_deg.delete();
    endtask

    task automatic accept(input bit is_inc, input int n);
        if (is_inc) begin
            if (model[n] == DMAX) m_ovf = 1'b1;
            else                  model[n] = model[n] + 1;
        end else if (model[n] == 0) begin
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
            m_ufl = 1'b1;
`else
            model[n] = DMAX;
            exp_deg.push_back(DMAX);
`endif
        end else begin
            model[n] = model[n] - 1;
            exp_deg.push_back(model[n]);
            if (model[n] == 0) exp_zq.push_back(n);
        end
    endtask

    task automatic step_zq();
        if (rand_zq) zq_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic req(input bit is_inc, input int n);
        int  waited = 0;
        bit  done   = 1'b0;
        @(negedge clk);
        step_zq();
        inc_valid = is_inc;
        dec_valid = !is_inc;
        inc_node  = NW'(n);
        dec_node  = NW'(n);
        while (!done) begin
            #1;
            if (is_inc ? inc_ready : dec_ready) begin
                @(posedge clk);
                accept(is_inc, n);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 60) begin
                    chk("req_timeout", waited, 0);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    step_zq();
                end
            end
        end
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(negedge clk);
            inc_valid = 1'b0;
            dec_valid = 1'b0;
            step_zq();
        end
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, 16);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        inc_valid = 1'b0;
        dec_valid = 1'b0;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
    endtask

    initial begin
        int waited;
        bit done;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_deg_valid", {31'd0, deg_valid}, 0);
        chk("rst_deg_value", {30'd0, deg_value}, 0);
        chk("rst_zq_valid", {31'd0, zq_valid}, 0);
        chk("rst_zq_node", {28'd0, zq_node}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_inc_ready", {31'd0, inc_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy("reset_busy_cycles");

        // Every entry starts at zero
        zq_ready = 1'b1;
        for (int n = 0; n < N; n++) begin
            req(1'b1, n);
            req(1'b0, n);
        end
        idle(4);

        // Back-to-back increments then decrements on node 5
        repeat (3) req(1'b1, 5);
        repeat (3) req(1'b0, 5);
        idle(4);

        // Simultaneous inc/dec on node 7 holding 1
        req(1'b1, 7);
        @(negedge clk);
        inc_valid = 1'b1; inc_node = 4'd7;
        dec_valid = 1'b1; dec_node = 4'd7;
        #1;
        chk("both_inc_ready", {31'd0, inc_ready}, 1);
        chk("both_dec_stall", {31'd0, dec_ready}, 0);
        @(posedge clk);
        accept(1'b1, 7);
        @(negedge clk);
        inc_valid = 1'b0;
        #1;
        chk("both_dec_next", {31'd0, dec_ready}, 1);
        @(posedge clk);
        accept(1'b0, 7);
        req(1'b0, 7);
        idle(4);

        // Queue backpressure with zq_ready low
        zq_ready = 1'b0;
        for (int n = 1; n <= 4; n++) req(1'b1, n);
        for (int n = 1; n <= 3; n++) req(1'b0, n);
        @(negedge clk);
        inc_valid = 1'b0;
        dec_valid = 1'b1; dec_node = 4'd4;
        #1;
        chk("zq_full_dec_ready", {31'd0, dec_ready}, 0);
        chk("zq_full_valid", {31'd0, zq_valid}, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("zq_full_hold", {31'd0, dec_ready}, 0);
        zq_ready = 1'b1;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            if (dec_ready) begin
                @(posedge clk);
                accept(1'b0, 4);
                done = 1'b1;
            end else if (waited > 20) begin
                chk("zq_drain_timeout", waited, 0);
                done = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                waited++;
            end
        end
        idle(8);

        // Saturation on node 1
        #1;
        chk("ovf_before", {31'd0, overflow}, 0);
        repeat (4) req(1'b1, 1);
        idle(1);
        #1;
        chk("ovf_after", {31'd0, overflow}, 1);
        repeat (3) req(1'b0, 1);
        idle(4);

        // Decrement of an empty entry
        req(1'b0, 9);
        idle(3);
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
        #1;
        chk("underflow_set", {31'd0, underflow}, 1);
`endif

        // Clear with queued data, then again mid-sweep
        zq_ready = 1'b0;
        req(1'b1, 2);
        req(1'b0, 2);
        idle(3);
        clear_pulse();
        chk("clear_zq_valid", {31'd0, zq_valid}, 0);
        chk("clear_overflow", {31'd0, overflow}, 0);
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
        chk("clear_underflow", {31'd0, underflow}, 0);
`endif
        count_busy("clear_busy_cycles");
        repeat (3) req(1'b1, 6);
        clear_pulse();
        repeat (5) @(posedge clk);
        clear_pulse();
        count_busy("midsweep_busy_cycles");
        zq_ready = 1'b1;
        req(1'b1, 6);
        req(1'b0, 6);
        idle(3);

        // Randomized traffic
        rand_zq = 1'b1;
        repeat (300) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 0) idle(1);
            else         req(op == 1, int'($urandom_range(0, 7)));
        end
        rand_zq  = 1'b0;
        idle(1);
        zq_ready = 1'b1;
        idle(12);
        #1;
        chk("final_deg_pending", exp_deg.size(), 0);
        chk("final_zq_pending", exp_zq.size(), 0);
        chk("final_overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
        chk("final_underflow", {31'd0, underflow}, {31'd0, m_ufl});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/indegree_tracker.md
INDEGREE_TRACKER -- requirements
Module: indegree_tracker

Interface
REQ-001 The block SHALL have parameter MAX_NODES, default 1024, giving the number of table entries.
REQ-002 The block SHALL have parameter NODE_WIDTH, default $clog2(MAX_NODES), giving the node index width.
REQ-003 The block SHALL have parameter DEGREE_WIDTH, default 8, giving the stored degree counter width.
REQ-004 The block SHALL have parameter ZQ_DEPTH, default 16 (power of two, >=4), giving the zero-degree queue depth.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous pulse that restarts the table sweep.
REQ-008 The block SHALL have port busy, output, 1 bit: high while the clear sweep runs.
REQ-009 The block SHALL have ports inc_valid (input, 1), inc_ready (output, 1) and inc_node (input, NODE_WIDTH): edge-entry increment request.
REQ-010 The block SHALL have ports dec_valid (input, 1), dec_ready (output, 1) and dec_node (input, NODE_WIDTH): decrement request.
REQ-011 The block SHALL have ports deg_valid (output, 1) and deg_value (output, DEGREE_WIDTH): post-decrement degree.
REQ-012 The block SHALL have ports zq_valid (output, 1), zq_ready (input, 1) and zq_node (output, NODE_WIDTH): stream of nodes whose degree reached zero.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag set on increment saturation.

Function
REQ-014 The block SHALL use a two-state FSM, CLEAR and RUN; CLEAR SHALL write 0 to entries 0..MAX_NODES-1, one per cycle, then go to RUN; busy SHALL equal (state==CLEAR).
REQ-015 Each accepted request SHALL be a read-modify-write: the table is read in the acceptance cycle and written one cycle later, giving a two-stage pipeline that accepts one request per cycle.
REQ-016 A request SHALL be accepted when valid and ready are both high on a clock edge.
REQ-017 When both inc_valid and dec_valid are high, the increment SHALL win; dec_ready SHALL be low that cycle.
REQ-018 inc_ready and dec_ready SHALL be low in CLEAR.
REQ-019 dec_ready SHALL also be low while the zero queue has fewer than 2 free entries.
REQ-020 If the read stage addresses the node being written in the same cycle, the read SHALL use the forwarded write value, never stale RAM data.
REQ-021 An increment of an entry holding 2^DEGREE_WIDTH-1 SHALL leave the entry unchanged and set overflow.
REQ-022 An accepted decrement SHALL drive deg_valid high for exactly one cycle, one cycle after acceptance, with deg_value = old-1.
REQ-023 When that result is 0, dec_node SHALL be pushed into the zero queue in the same cycle.
REQ-024 The zero queue SHALL be FWFT: zq_node is valid whenever zq_valid=1, and it pops on zq_valid&&zq_ready.
REQ-025 Simultaneous push and pop SHALL be legal at any occupancy, including full and empty.
REQ-026 A clear pulse SHALL flush the pipeline, empty the queue, clear overflow, and re-enter CLEAR at entry 0, including mid-sweep.

Reset
REQ-027 When rst_n=0, the FSM SHALL enter CLEAR at entry 0.
REQ-028 When rst_n=0, pipeline valids, queue pointers and count, overflow, deg_valid and zq_valid SHALL be 0.
REQ-029 When rst_n=0, busy SHALL be 1 and deg_value and zq_node SHALL be 0.
REQ-030 RAM contents SHALL NOT be reset; only the sweep initialises them.
REQ-031 Sweep progress SHALL begin on the first clk edge after rst_n deasserts.

Configuration
REQ-032 With INDEGREE_UNDERFLOW_CHECK_EN defined, a decrement of an entry holding 0 SHALL leave it 0, produce no deg_valid and no queue push, and set a sticky output port underflow (1 bit, reset 0, cleared by clear).
REQ-033 Without INDEGREE_UNDERFLOW_CHECK_EN, the underflow port SHALL be absent and the decrement SHALL wrap to 2^DEGREE_WIDTH-1 with deg_valid asserted.

Verification
REQ-034 Bench SHALL check: rst_n pulse with MAX_NODES=16 -> busy high for exactly 16 cycles after release, and every entry then reads 0 via increment/decrement.
REQ-035 Bench SHALL check: increment node 5 on three consecutive cycles, then decrement it three times -> deg_value 2,1,0, and zq_node=5 pushed once.
REQ-036 Bench SHALL check: increment and decrement node 7 in the same cycle while the entry holds 1 -> increment accepted, decrement stalls one cycle, deg_value=1.
REQ-037 Bench SHALL check: zq_ready=0 with ZQ_DEPTH=4, after driving zero-degree nodes -> dec_ready drops once queue occupancy reaches 3, there is no loss, and nodes drain in order when zq_ready=1.
REQ-038 Bench SHALL check: DEGREE_WIDTH=2 with node 1 incremented 4 times -> entry holds 3 and overflow=1.
REQ-039 Bench SHALL check: decrement of a 0 entry -> underflow=1 when the macro is defined, and deg_value=3 (DEGREE_WIDTH=2) when it is not.
